// File: rtl/cla_bist_pkg.sv
// Shared definitions for the carry-lookahead adder self-test (cla_bist).
//   - state_e : sweep FSM state encoding
//   - vec_w   : vector index width for a given operand width (2*WIDTH+1)
//   - sat_inc : saturating increment for a counter of a given width
package cla_bist_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StApply = 3'd1,
    StWait  = 3'd2,
    StCheck = 3'd3,
    StDone  = 3'd4
  } state_e;

  // One bit per A and B operand bit plus the carry-in.
  function automatic int unsigned vec_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Increment val, sticking at the all-ones value of a width-bit counter (width <= 63).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/cla_bist_vecgen.sv
// Vector counter for the adder sweep.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_clr           : reset the vector index to 0 (sweep start)
//   i_inc           : advance to the next vector
//   o_v             : current vector index
//   o_last          : index is the final vector (all ones)
//   o_a, o_b, o_cin : operand/carry slices of the current index
module cla_bist_vecgen
  import cla_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [2*WIDTH:0] o_v,
  output logic             o_last,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin
);

  localparam int unsigned VEC_W = vec_w(WIDTH);

  logic [VEC_W-1:0] r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (i_clr) begin
      r_v <= '0;
    end else if (i_inc) begin
      r_v <= r_v + VEC_W'(1);
    end
  end

  assign o_v    = r_v;
  assign o_last = &r_v;
  assign o_a    = r_v[WIDTH-1:0];
  assign o_b    = r_v[2*WIDTH-1:WIDTH];
  assign o_cin  = r_v[2*WIDTH];

endmodule

// File: rtl/cla_bist.sv
// On-chip exhaustive self-test for a combinational WIDTH-bit carry-lookahead adder.
// Drives every {Cin,B,A} combination, waits SETTLE cycles, compares {Cout,S} against
// the arithmetic sum and counts mismatches (saturating).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin sweep (IDLE/DONE only) / stop sweep (busy only)
//   A, B, Cin           : registered operands to the adder
//   S, Cout             : adder results
//   busy, done, pass    : status; pass = done with zero errors
//   err_count, vec_idx  : mismatch count, current vector index
// Optional build macro CLA_BIST_FIRST_FAIL_EN adds fail_valid/fail_idx/fail_S/fail_Cout,
// capturing the first mismatching vector of a sweep.
module cla_bist
  import cla_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERRW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] S,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [2*WIDTH:0] vec_idx
`ifdef CLA_BIST_FIRST_FAIL_EN
  ,
  output logic             fail_valid,
  output logic [2*WIDTH:0] fail_idx,
  output logic [WIDTH-1:0] fail_S,
  output logic             fail_Cout
`endif
);

  localparam int unsigned VEC_W = vec_w(WIDTH);
  localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           r_state, w_state_nxt;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_cin;
  logic [ERRW-1:0]  r_err_count;

  logic             w_vec_clr, w_vec_inc, w_opnd_load, w_opnd_clr, w_sweep_clr, w_check;
  logic [VEC_W-1:0] w_v;
  logic             w_last;
  logic [WIDTH-1:0] w_a, w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_golden;
  logic             w_mismatch;

  cla_bist_vecgen #(
    .WIDTH (WIDTH)
  ) u_vecgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_vec_clr),
    .i_inc  (w_vec_inc),
    .o_v    (w_v),
    .o_last (w_last),
    .o_a    (w_a),
    .o_b    (w_b),
    .o_cin  (w_cin)
  );

  // Next state. abort takes priority in every busy state; a vector under CHECK when
  // abort arrives is neither counted nor advanced.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_clr   = 1'b0;
    w_vec_inc   = 1'b0;
    w_opnd_load = 1'b0;
    w_opnd_clr  = 1'b0;
    w_sweep_clr = 1'b0;
    w_check     = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start && !abort) begin
          w_state_nxt = StApply;
          w_vec_clr   = 1'b1;
          w_sweep_clr = 1'b1;
        end
      end
      StApply: begin
        if (abort) begin
          w_state_nxt = StIdle;
          w_opnd_clr  = 1'b1;
        end else begin
          w_opnd_load = 1'b1;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          w_state_nxt = StIdle;
          w_opnd_clr  = 1'b1;
        end else if (r_settle == SW'(SETTLE - 1)) begin
          w_state_nxt = StCheck;
        end
      end
      StCheck: begin
        if (abort) begin
          w_state_nxt = StIdle;
          w_opnd_clr  = 1'b1;
        end else begin
          w_check = 1'b1;
          if (w_last) begin
            w_state_nxt = StDone;
          end else begin
            w_vec_inc   = 1'b1;
            w_state_nxt = StApply;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counts cycles spent in WAIT; restarts from 0 on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (r_state != StWait) begin
      r_settle <= '0;
    end else begin
      r_settle <= r_settle + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else if (w_opnd_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else if (w_opnd_load) begin
      r_a   <= w_a;
      r_b   <= w_b;
      r_cin <= w_cin;
    end
  end

  assign w_golden   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_mismatch = ({Cout, S} != w_golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_sweep_clr) begin
      r_err_count <= '0;
    end else if (w_check && w_mismatch) begin
      r_err_count <= ERRW'(sat_inc(64'(r_err_count), ERRW));
    end
  end

`ifdef CLA_BIST_FIRST_FAIL_EN
  logic             r_fail_valid;
  logic [VEC_W-1:0] r_fail_idx;
  logic [WIDTH-1:0] r_fail_s;
  logic             r_fail_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_s     <= '0;
      r_fail_cout  <= 1'b0;
    end else if (w_sweep_clr) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_s     <= '0;
      r_fail_cout  <= 1'b0;
    end else if (w_check && w_mismatch && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_idx   <= w_v;
      r_fail_s     <= S;
      r_fail_cout  <= Cout;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
  assign fail_S     = r_fail_s;
  assign fail_Cout  = r_fail_cout;
`endif

  assign A         = r_a;
  assign B         = r_b;
  assign Cin       = r_cin;
  assign busy      = (r_state == StApply) || (r_state == StWait) || (r_state == StCheck);
  assign done      = (r_state == StDone);
  assign pass      = done && (r_err_count == '0);
  assign err_count = r_err_count;
  assign vec_idx   = w_v;

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: a behavioural adder with selectable faults responds to the BIST,
// and expected results come from enumerating all vectors with plain arithmetic.
module tb_cla_bist;

  localparam int NV = 512;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;

  logic [3:0] a, b, s;
  logic       cin, cout, busy, done, pass;
  logic [15:0] err;
  logic [8:0] vidx;

  logic [3:0] a4, b4, s4;
  logic       cin4, cout4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [8:0] vidx4;

`ifdef CLA_BIST_FIRST_FAIL_EN
  logic       fvalid, fcout, fvalid4, fcout4;
  logic [8:0] fidx, fidx4;
  logic [3:0] fs, fs4;
`endif

  int   mode;
  logic bad_tbl [NV];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Adder response: 0 good, 1 S[0] stuck-at-0, 2 Cout stuck-at-0, 3 S[0] flipped on
  // randomly chosen vectors.
  function automatic logic [4:0] adder_out(input int md, input int v);
    logic [3:0] oa, ob;
    logic       oc;
    logic [4:0] r;
    oa = 4'(v);
    ob = 4'(v >> 4);
    oc = 1'(v >> 8);
    r  = {1'b0, oa} + {1'b0, ob} + {4'b0, oc};
    case (md)
      1:       r[0] = 1'b0;
      2:       r[4] = 1'b0;
      3:       if (bad_tbl[v]) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  function automatic int golden(input int v);
    return (v % 16) + ((v / 16) % 16) + (v / 256);
  endfunction

  // Mismatching vectors among indices 0..upto-1.
  function automatic int exp_errs(input int md, input int upto);
    int n;
    n = 0;
    for (int v = 0; v < upto; v++) if (int'(adder_out(md, v)) != golden(v)) n++;
    return n;
  endfunction

  function automatic int first_fail(input int md);
    for (int v = 0; v < NV; v++) if (int'(adder_out(md, v)) != golden(v)) return v;
    return 0;
  endfunction

  always_comb {cout, s} = adder_out(mode, int'({cin, b, a}));
  always_comb {cout4, s4} = adder_out(1, int'({cin4, b4, a4}));

  cla_bist #(
    .WIDTH  (4),
    .SETTLE (2),
    .ERRW   (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .S         (s),
    .Cout      (cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err),
    .vec_idx   (vidx)
`ifdef CLA_BIST_FIRST_FAIL_EN
    ,
    .fail_valid (fvalid),
    .fail_idx   (fidx),
    .fail_S     (fs),
    .fail_Cout  (fcout)
`endif
  );

  cla_bist #(
    .WIDTH  (4),
    .SETTLE (2),
    .ERRW   (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .A         (a4),
    .B         (b4),
    .Cin       (cin4),
    .S         (s4),
    .Cout      (cout4),
    .busy      (busy4),
    .done      (done4),
    .pass      (pass4),
    .err_count (err4),
    .vec_idx   (vidx4)
`ifdef CLA_BIST_FIRST_FAIL_EN
    ,
    .fail_valid (fvalid4),
    .fail_idx   (fidx4),
    .fail_S     (fs4),
    .fail_Cout  (fcout4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then count cycles until done; a stray start mid-sweep must be ignored.
  task automatic run_sweep(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_clr_on_start", 64'(err), 64'd0);
    check("done_clr_on_start", 64'(done), 64'd0);
    cyc = 0;
    while (!done && cyc < 5000) begin
      start = (cyc == 50);
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    int ee;
    mode = 0;
    for (int i = 0; i < NV; i++) bad_tbl[i] = 1'b0;

    // Reset values (asynchronous: checked before any clock edge).
    #1 rst_n = 1'b0;
    #2;
    check("rst_A", 64'(a), 64'd0);
    check("rst_B", 64'(b), 64'd0);
    check("rst_Cin", 64'(cin), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_vidx", 64'(vidx), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Good adder: full sweep.
    run_sweep(cyc);
    check("good_cycles", 64'(cyc), 64'd2048);
    check("good_pass", 64'(pass), 64'd1);
    check("good_err", 64'(err), 64'd0);
    check("good_vidx", 64'(vidx), 64'(NV - 1));
    check("good_hold_A", 64'(a), 64'd15);
    check("good_hold_B", 64'(b), 64'd15);
    check("good_hold_Cin", 64'(cin), 64'd1);
    check("sat_done", 64'(done4), 64'd1);
    check("sat_err", 64'(err4), 64'd15);
    check("sat_pass", 64'(pass4), 64'd0);

    // Faulty adders, restarted from DONE each time.
    for (int md = 1; md <= 3; md++) begin
      if (md == 3) for (int i = 0; i < NV; i++) bad_tbl[i] = ($urandom_range(0, 15) == 0);
      mode = md;
      ee   = exp_errs(md, NV);
      run_sweep(cyc);
      check("fault_cycles", 64'(cyc), 64'd2048);
      check("fault_err", 64'(err), 64'(ee));
      check("fault_pass", 64'(pass), 64'(ee == 0));
`ifdef CLA_BIST_FIRST_FAIL_EN
      if (ee != 0) begin
        check("ff_valid", 64'(fvalid), 64'd1);
        check("ff_idx", 64'(fidx), 64'(first_fail(md)));
        check("ff_S", 64'(fs), 64'(adder_out(md, first_fail(md)) & 5'h0f));
        check("ff_Cout", 64'(fcout), 64'(adder_out(md, first_fail(md)) >> 4));
      end
`endif
    end

    // Abort at a random point: vectors fully checked so far are n/4 (4 cycles each).
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = $urandom_range(20, 1500);
    repeat (n) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_A", 64'(a), 64'd0);
    check("abort_B", 64'(b), 64'd0);
    check("abort_Cin", 64'(cin), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_vidx", 64'(vidx), 64'(n / 4));
    check("abort_err", 64'(err), 64'(exp_errs(1, n / 4)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_vidx", 64'(vidx), 64'(n / 4));
    check("abort_idle_busy", 64'(busy), 64'd0);

    mode = 0;
    run_sweep(cyc);
    check("post_abort_cycles", 64'(cyc), 64'd2048);
    check("post_abort_pass", 64'(pass), 64'd1);

    // Reset mid-sweep returns everything to zero immediately.
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(100, 1500)) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_A", 64'(a), 64'd0);
    check("mid_rst_B", 64'(b), 64'd0);
    check("mid_rst_Cin", 64'(cin), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_vidx", 64'(vidx), 64'd0);
`ifdef CLA_BIST_FIRST_FAIL_EN
    check("mid_rst_ffvalid", 64'(fvalid), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 64'(done), 64'd0);

    mode = 0;
    run_sweep(cyc);
    check("post_rst_cycles", 64'(cyc), 64'd2048);
    check("post_rst_pass", 64'(pass), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
